// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the two-channel button conditioner (package btn_pkg).
// Holds the per-channel FSM state encoding, default timing constants and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce and 1 s long-press hold at 27 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;
  localparam int DEFAULT_LONG_CYCLES     = 27000000;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter, registered pulses.
// Long-press hold counter is only built when LONG_PRESS_EN is defined.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    r_sync;
  btn_state_t    r_state;
  btn_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_low;
  logic          w_press_next;
  logic          w_release_next;
  logic          w_level_next;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  assign w_low     = ~r_sync[1];
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn_n};
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_low) begin
          w_state_next = ST_PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_low) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = ST_PRESSED;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!w_low) begin
          w_state_next = ST_RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_low) begin
          w_state_next = ST_PRESSED;
        end else if (r_cnt == DB_LAST) begin
          w_state_next   = ST_IDLE;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_level_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_RELEASE_WAIT);
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [CW-1:0] r_hold;
  logic          r_long_done;
  logic          r_long;

  // Hold time only accrues while PRESSED; a bounce through RELEASE_WAIT pauses it without restarting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == ST_IDLE || r_state == ST_PRESS_WAIT) begin
        r_hold      <= '0;
        r_long_done <= 1'b0;
      end else if (r_state == ST_PRESSED) begin
        if (r_hold == LONG_LAST) begin
          if (!r_long_done) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end
  end

  assign o_long_press = r_long;
`else
  assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Two-channel debouncer for active-low board buttons with press/release/long-press pulses.
// Long-press detection is enabled by defining LONG_PRESS_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn_n,
  output logic [1:0] level,
  output logic [1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [1:0] release_pulse,
  output logic [1:0] long_press
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_btn_n     (btn_n[gi]),
      .o_level     (level[gi]),
      .o_press     (press[gi]),
      .o_release   (release_pulse[gi]),
      .o_long_press(long_press[gi])
    );
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, giving the stable-input cycles required to accept a change (10 ms at 27 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_CYCLES, default 27000000, giving the held cycles after acceptance of a press before a long press is flagged (1 s at 27 MHz); legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single 27 MHz clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn_n, input, 2 bits: raw board buttons, active-low, asynchronous to clk, bouncing.
REQ-006 SHALL have port level, output, 2 bits: debounced state per channel, 1 = pressed.
REQ-007 SHALL have port press, output, 2 bits: one-cycle pulse per channel when a press is accepted.
REQ-008 SHALL have port release, output, 2 bits: one-cycle pulse per channel when a release is accepted.
REQ-009 SHALL have port long_press, output, 2 bits: one-cycle pulse per channel on a long press; the port is present in all builds.

Function
REQ-010 SHALL pass each btn_n bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL run one independent FSM per channel with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: on synced low, go to PRESS_WAIT and clear the counter.
REQ-013 PRESS_WAIT: on synced high, return to IDLE with no output. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1, go to PRESSED.
REQ-014 PRESSED: on synced high, go to RELEASE_WAIT and clear the counter.
REQ-015 RELEASE_WAIT: on synced low, return to PRESSED with no output. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1, go to IDLE.
REQ-016 SHALL register all outputs.
REQ-017 press is asserted for exactly one cycle, DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_n low, provided btn_n stays low throughout.
REQ-018 release SHALL follow the same latency rule on the high-going side.
REQ-019 level = 1 in PRESSED and RELEASE_WAIT, else 0; level rises in the same cycle as press and falls in the same cycle as release.
REQ-020 Bounce shorter than DEBOUNCE_CYCLES stable cycles SHALL produce no pulse and no level change.
REQ-021 Counter width SHALL be $clog2 of the larger of DEBOUNCE_CYCLES and LONG_CYCLES; the counter never wraps and saturates at its terminal value.
REQ-022 Simultaneous activity on both channels SHALL be handled independently with no interaction.
REQ-023 press and release for one channel are never asserted in the same cycle.

Reset
REQ-024 While rst_n is low, all outputs SHALL be 0 asynchronously, FSMs SHALL be in IDLE, counters 0, and synchronizer flops 1 (released).
REQ-025 A button held across reset deassertion SHALL be treated as a new press (press pulse after DEBOUNCE_CYCLES+3 edges).

Configuration
REQ-026 Macro LONG_PRESS_EN SHALL control long-press detection.
REQ-027 With LONG_PRESS_EN defined: in PRESSED a hold counter increments, and long_press pulses once LONG_CYCLES cycles after the press pulse. Only one long_press per press; the counter saturates; the count is cleared on leaving PRESSED/RELEASE_WAIT to IDLE; a bounce into RELEASE_WAIT and back does not restart it.
REQ-028 Without LONG_PRESS_EN: long_press is tied to 0 and no hold-counter logic is synthesized.

Structure
REQ-029 Shared package btn_pkg SHALL hold the FSM state typedef (2-bit enum) and the default cycle constants.
REQ-030 Per-channel FSM, counter and synchronizer SHALL live in sub-module debounce_channel, instantiated twice by generate.

Verification (DEBOUNCE_CYCLES=5, LONG_CYCLES=20)
REQ-031 Reset: rst_n=0 with btn_n=2'b00 -> all outputs 0 immediately; release reset with btn_n=2'b11 -> outputs stay 0 for 50 cycles.
REQ-032 Clean press: btn_n[0] low for 30 cycles -> press[0] single pulse on edge 8, level[0]=1 from edge 8; channel 1 outputs stay 0.
REQ-033 Bounce: btn_n[0] alternates 3 low / 1 high for 16 cycles, then high -> no press, release, or level change.
REQ-034 Release: from PRESSED, btn_n[0] high -> release[0] pulse on edge 8 after the rising edge, level[0]=0 the same cycle.
REQ-035 Long press: LONG_PRESS_EN defined, hold 40 cycles -> exactly one long_press[0] pulse, 20 cycles after the press pulse. Macro undefined -> long_press stays 0.
REQ-036 Reset mid-operation: rst_n low for 2 cycles while PRESSED with the button held -> level=0 asynchronously; after deassert -> new press pulse on edge 8.
